// File: rtl/rfw_pkg.sv
// Shared types and helpers for the register-file write arbiter.
package rfw_pkg;

    localparam int RFW_WIDTH      = 32;
    localparam int RFW_SIZE       = 64;
    localparam int RFW_AW         = $clog2(RFW_SIZE);
    localparam int RFW_FIFO_DEPTH = 4;

    typedef struct packed {
        logic [RFW_AW-1:0]    addr;
        logic [RFW_WIDTH-1:0] data;
    } rfw_entry_t;

    // One extra pointer bit distinguishes full from empty when the low bits match.
    function automatic int rfw_ptr_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/rfw_fifo.sv
// Per-source writeback FIFO: power-of-2 depth, wrap-bit pointers, registered head.
module rfw_fifo
    import rfw_pkg::*;
#(
    parameter int  DEPTH   = RFW_FIFO_DEPTH,
    parameter type entry_t = rfw_entry_t
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   push,
    input  logic   pop,
    input  entry_t din,
    output logic   full,
    output logic   empty,
    output entry_t head
);

    localparam int PW = rfw_ptr_w(DEPTH);

    entry_t        mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;

    assign full  = (wr_ptr[PW-1] != rd_ptr[PW-1]) && (wr_ptr[PW-2:0] == rd_ptr[PW-2:0]);
    assign empty = (wr_ptr == rd_ptr);
    assign head  = mem[rd_ptr[PW-2:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full)
                wr_ptr <= wr_ptr + PW'(1);
            if (pop && !empty)
                rd_ptr <= rd_ptr + PW'(1);
        end
    end

    // Storage carries no reset; only the pointers define which entries are live.
    always_ff @(posedge clk) begin
        if (push && !full)
            mem[wr_ptr[PW-2:0]] <= din;
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Buffers writebacks from NUM_SRC producers and issues up to NUM_WRITE RegFile writes per cycle.
// Optional macro RFW_COLLISION_AVOID_EN holds back heads whose address is being read this cycle.
module regfile_write_arbiter
    import rfw_pkg::*;
#(
    parameter int  WIDTH      = RFW_WIDTH,
    parameter int  SIZE       = RFW_SIZE,
    parameter int  NUM_SRC    = 4,
    parameter int  NUM_WRITE  = 2,
    parameter int  NUM_READ   = 8,
    parameter int  FIFO_DEPTH = RFW_FIFO_DEPTH,
    localparam int AW         = $clog2(SIZE)
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [NUM_SRC-1:0]                IN_valid,
    input  logic [NUM_SRC-1:0][AW-1:0]        IN_addr,
    input  logic [NUM_SRC-1:0][WIDTH-1:0]     IN_data,
    output logic [NUM_SRC-1:0]                OUT_ready,
    input  logic [NUM_READ-1:0]               IN_re,
    input  logic [NUM_READ-1:0][AW-1:0]       IN_raddr,
    output logic [NUM_WRITE-1:0]              OUT_we,
    output logic [NUM_WRITE-1:0][AW-1:0]      OUT_waddr,
    output logic [NUM_WRITE-1:0][WIDTH-1:0]   OUT_wdata,
    output logic                              OUT_idle
);

    localparam int SW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    typedef struct packed {
        logic [AW-1:0]    addr;
        logic [WIDTH-1:0] data;
    } entry_t;

    entry_t             din   [NUM_SRC];
    entry_t             head  [NUM_SRC];
    logic [NUM_SRC-1:0] full;
    logic [NUM_SRC-1:0] empty;
    logic [NUM_SRC-1:0] push;
    logic [NUM_SRC-1:0] pop;
    logic [NUM_SRC-1:0] elig;
    logic [SW-1:0]      rr_ptr;
    logic [SW-1:0]      rr_next;
    logic [SW-1:0]      idx;
    logic               hit;
    int                 n_grant;

    for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
        assign push[g] = IN_valid[g] & ~full[g];
        assign din[g]  = '{addr: IN_addr[g], data: IN_data[g]};

        rfw_fifo #(
            .DEPTH   (FIFO_DEPTH),
            .entry_t (entry_t)
        ) u_fifo (
            .clk   (clk),
            .rst_n (rst_n),
            .push  (push[g]),
            .pop   (pop[g]),
            .din   (din[g]),
            .full  (full[g]),
            .empty (empty[g]),
            .head  (head[g])
        );
    end

    assign OUT_ready = ~full;
    assign OUT_idle  = &empty;

`ifdef RFW_COLLISION_AVOID_EN
    always_comb begin
        elig = ~empty;
        for (int s = 0; s < NUM_SRC; s++) begin
            for (int j = 0; j < NUM_READ; j++) begin
                if (IN_re[j] && (IN_raddr[j] == head[s].addr))
                    elig[s] = 1'b0;
            end
        end
    end
`else
    logic unused_rd;
    assign unused_rd = ^{IN_re, IN_raddr};
    assign elig      = ~empty;
`endif

    // Rotating scan from rr_ptr; grant k lands on port k, same-address heads wait a cycle.
    always_comb begin
        pop       = '0;
        OUT_we    = '0;
        OUT_waddr = 'x;
        OUT_wdata = 'x;
        rr_next   = rr_ptr;
        idx       = rr_ptr;
        hit       = 1'b0;
        n_grant   = 0;
        for (int k = 0; k < NUM_SRC; k++) begin
            idx = SW'((int'(rr_ptr) + k) % NUM_SRC);
            hit = 1'b0;
            for (int p = 0; p < NUM_WRITE; p++) begin
                if ((p < n_grant) && (OUT_waddr[p] == head[idx].addr))
                    hit = 1'b1;
            end
            if ((n_grant < NUM_WRITE) && elig[idx] && !hit) begin
                for (int p = 0; p < NUM_WRITE; p++) begin
                    if (p == n_grant) begin
                        OUT_we[p]    = 1'b1;
                        OUT_waddr[p] = head[idx].addr;
                        OUT_wdata[p] = head[idx].data;
                    end
                end
                pop[idx] = 1'b1;
                rr_next  = (idx == SW'(NUM_SRC - 1)) ? '0 : idx + SW'(1);
                n_grant  = n_grant + 1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            rr_ptr <= '0;
        else
            rr_ptr <= rr_next;
    end

endmodule
